// File: rtl/mem_cmd_queue.sv
// Request FIFO and single-outstanding command sequencer placed in front of memory_controller.
// Legal READ/WRITE requests are queued, issued one at a time, and answered on the rsp_* port.
module mem_cmd_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [1:0]             req_cmd,
    input  logic [24:0]            req_addr,
    input  logic [15:0]            req_wdata,
    output logic                   req_ready,
    output logic [1:0]             cmd,
    output logic [24:0]            addr,
    output logic [15:0]            wr_dq,
    output logic                   ready,
    input  logic                   valid,
    input  logic [15:0]            rd_dq,
    output logic                   rsp_valid,
    output logic                   rsp_is_read,
    output logic [15:0]            rsp_data,
    output logic [24:0]            rsp_addr,
    output logic                   err_illegal,
    output logic                   err_timeout,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [24:0] addr;
        logic [15:0] wdata;
    } entry_t;

    entry_t           fifo_q [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             req_legal, push, pop;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [24:0]      addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             rsp_is_read_q, rsp_is_read_d;
    logic [15:0]      rsp_data_q, rsp_data_d;
    logic [24:0]      rsp_addr_q, rsp_addr_d;
    logic             err_illegal_q, err_timeout_q, err_timeout_d;

    // Full is judged on the registered level, so a pop in the same cycle never opens room.
    assign req_ready = (level_q != LVL_W'(DEPTH));
    assign req_legal = (req_cmd == CMD_READ) || (req_cmd == CMD_WRITE);
    assign push      = req_valid && req_ready && req_legal;
    assign head      = fifo_q[rd_ptr_q];

    // NOTE: storage carries no reset; level and the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{cmd: req_cmd, addr: req_addr, wdata: req_wdata};
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_is_read_d = rsp_is_read_q;
        rsp_data_d    = rsp_data_q;
        rsp_addr_d    = rsp_addr_q;
        err_timeout_d = 1'b0;
        pop           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    cmd_d   = head.cmd;
                    addr_d  = head.addr;
                    wdata_d = head.wdata;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion arriving on the final count still wins over the timeout.
                if (valid) begin
                    rsp_is_read_d = (cmd_q == CMD_READ);
                    rsp_data_d    = (cmd_q == CMD_READ) ? rd_dq : 16'h0000;
                    rsp_addr_d    = addr_q;
                    state_d       = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    err_timeout_d = 1'b1;
                    cmd_d         = CMD_NONE;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                cmd_d   = CMD_NONE;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            cnt_q         <= '0;
            cmd_q         <= CMD_NONE;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_is_read_q <= 1'b0;
            rsp_data_q    <= '0;
            rsp_addr_q    <= '0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_is_read_q <= rsp_is_read_d;
            rsp_data_q    <= rsp_data_d;
            rsp_addr_q    <= rsp_addr_d;
            err_timeout_q <= err_timeout_d;
            err_illegal_q <= req_valid && !req_legal;

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign cmd         = cmd_q;
    assign addr        = addr_q;
    assign wr_dq       = wdata_q;
    assign ready       = (state_q == ST_ISSUE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_is_read = rsp_is_read_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_addr    = rsp_addr_q;
    assign err_illegal = err_illegal_q;
    assign err_timeout = err_timeout_q;
    assign level       = level_q;

endmodule

// File: tb/tb_mem_cmd_queue.sv
// Directed bench for mem_cmd_queue: a behavioural memory_controller model answers issued
// commands, and a scoreboard of expected responses is drained as rsp_valid strobes arrive.
`timescale 1ns/1ps
module tb_mem_cmd_queue;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;
    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] WR = 2'b10;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   req_valid;
    logic [1:0]             req_cmd;
    logic [24:0]            req_addr;
    logic [15:0]            req_wdata;
    logic                   req_ready;
    logic [1:0]             cmd;
    logic [24:0]            addr;
    logic [15:0]            wr_dq;
    logic                   ready;
    logic                   valid;
    logic [15:0]            rd_dq;
    logic                   rsp_valid;
    logic                   rsp_is_read;
    logic [15:0]            rsp_data;
    logic [24:0]            rsp_addr;
    logic                   err_illegal;
    logic                   err_timeout;
    logic [$clog2(DEPTH):0] level;

    mem_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_cmd     (req_cmd),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .cmd         (cmd),
        .addr        (addr),
        .wr_dq       (wr_dq),
        .ready       (ready),
        .valid       (valid),
        .rd_dq       (rd_dq),
        .rsp_valid   (rsp_valid),
        .rsp_is_read (rsp_is_read),
        .rsp_data    (rsp_data),
        .rsp_addr    (rsp_addr),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout),
        .level       (level)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic        is_read;
        logic [15:0] data;
        logic [24:0] addr;
    } rsp_t;

    rsp_t sb [$];
    rsp_t mon_e;

    int n_checks      = 0;
    int n_fail        = 0;
    int rsp_count     = 0;
    int illegal_count = 0;
    int timeout_count = 0;
    int ready_count   = 0;

    bit  hold      = 1'b0;
    bit  drop_next = 1'b0;
    int  lat       = 8;
    logic [15:0] mem_model [logic [24:0]];
    logic [1:0]  m_cmd;
    logic [24:0] m_addr;
    logic [15:0] m_data;
    int          m_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_level"},       32'(level),       0);
        check({pfx, "_req_ready"},   32'(req_ready),   1);
        check({pfx, "_ready"},       32'(ready),       0);
        check({pfx, "_cmd"},         32'(cmd),         0);
        check({pfx, "_addr"},        32'(addr),        0);
        check({pfx, "_wr_dq"},       32'(wr_dq),       0);
        check({pfx, "_rsp_valid"},   32'(rsp_valid),   0);
        check({pfx, "_rsp_is_read"}, 32'(rsp_is_read), 0);
        check({pfx, "_rsp_data"},    32'(rsp_data),    0);
        check({pfx, "_rsp_addr"},    32'(rsp_addr),    0);
        check({pfx, "_err_illegal"}, 32'(err_illegal), 0);
        check({pfx, "_err_timeout"}, 32'(err_timeout), 0);
    endtask

    task automatic expect_rsp(input logic r, input logic [15:0] d, input logic [24:0] a);
        rsp_t e;
        e.is_read = r;
        e.data    = d;
        e.addr    = a;
        sb.push_back(e);
    endtask

    // Drives one request for one cycle, starting and ending on a falling edge.
    task automatic send(input logic [1:0] c, input logic [24:0] a, input logic [15:0] d);
        req_valid = 1'b1;
        req_cmd   = c;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        req_cmd   = 2'b00;
    endtask

    task automatic wait_rsps(input string tag, input int target, input int budget);
        int n = 0;
        while (rsp_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(rsp_count), 32'(target));
    endtask

    // memory_controller stand-in: sees ready, holds off while requested, then returns valid.
    always begin : ctrl_model
        @(negedge clk);
        if (rst && ready) begin
            ready_count++;
            m_cmd  = cmd;
            m_addr = addr;
            m_data = wr_dq;
            if (m_cmd == WR) mem_model[m_addr] = m_data;
            if (drop_next) begin
                drop_next = 1'b0;
            end else begin
                m_n = 0;
                while (rst && (hold || m_n < lat) && m_n < 200) begin
                    @(negedge clk);
                    m_n++;
                    if (rst) begin
                        check("wait_ready_low",   32'(ready), 0);
                        check("wait_cmd_stable",  32'(cmd),   32'(m_cmd));
                        check("wait_addr_stable", 32'(addr),  32'(m_addr));
                        check("wait_wdq_stable",  32'(wr_dq), 32'(m_data));
                    end
                end
                if (rst) begin
                    valid = 1'b1;
                    rd_dq = (m_cmd == RD && mem_model.exists(m_addr)) ? mem_model[m_addr] : 16'hDEAD;
                    @(negedge clk);
                    valid = 1'b0;
                    rd_dq = 16'h0000;
                end
            end
        end
    end

    always begin : rsp_monitor
        @(negedge clk);
        if (rst) begin
            if (err_illegal) illegal_count++;
            if (err_timeout) timeout_count++;
            if (rsp_valid) begin
                rsp_count++;
                n_checks++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL rsp_unexpected: observed response for addr %0h, expected none", rsp_addr);
                end
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("rsp_is_read", 32'(rsp_is_read), 32'(mon_e.is_read));
                    check("rsp_data",    32'(rsp_data),    32'(mon_e.data));
                    check("rsp_addr",    32'(rsp_addr),    32'(mon_e.addr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish by 200000 ns, expected earlier finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, k, base;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_cmd   = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        valid     = 1'b0;
        rd_dq     = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Single WRITE: two-cycle latency to ready, controller answers after 8 cycles.
        lat = 8;
        expect_rsp(1'b0, 16'h0000, 25'h0000123);
        send(WR, 25'h0000123, 16'hBEEF);
        check("t1_level_enq",   32'(level), 1);
        check("t1_ready_early", 32'(ready), 0);
        @(negedge clk);
        check("t1_ready_issue", 32'(ready), 1);
        check("t1_cmd",         32'(cmd),   32'(WR));
        check("t1_addr",        32'(addr),  32'h0000123);
        check("t1_wr_dq",       32'(wr_dq), 32'hBEEF);
        check("t1_level_pop",   32'(level), 0);
        wait_rsps("t1_rsp", 1, 40);
        repeat (2) @(negedge clk);
        check("t1_ready_pulses", 32'(ready_count), 1);
        check("t1_cmd_cleared",  32'(cmd), 0);

        // READ back the same word.
        lat = 3;
        expect_rsp(1'b1, 16'hBEEF, 25'h0000123);
        send(RD, 25'h0000123, 16'h0000);
        wait_rsps("t2_rsp", 2, 40);
        repeat (3) @(negedge clk);
        check("t2_rsp_exact",    32'(rsp_count),   2);
        check("t2_ready_pulses", 32'(ready_count), 2);

        // Fill with the controller stalled: one in flight, four queued, overflow refused.
        hold = 1'b1;
        lat  = 2;
        expect_rsp(1'b0, 16'h0000, 25'h0000200);
        send(WR, 25'h0000200, 16'h1111);
        expect_rsp(1'b0, 16'h0000, 25'h0000201);
        send(WR, 25'h0000201, 16'h2222);
        expect_rsp(1'b1, 16'h1111, 25'h0000200);
        send(RD, 25'h0000200, 16'h0000);
        expect_rsp(1'b1, 16'h2222, 25'h0000201);
        send(RD, 25'h0000201, 16'h0000);
        expect_rsp(1'b1, 16'hBEEF, 25'h0000123);
        send(RD, 25'h0000123, 16'h0000);
        check("t3_level_full",     32'(level),     4);
        check("t3_req_ready_full", 32'(req_ready), 0);
        send(WR, 25'h0000400, 16'h4444);
        check("t3_level_overflow", 32'(level),     4);
        base = illegal_count;
        send(2'b11, 25'h0000401, 16'h0000);
        @(negedge clk);
        check("t3_illegal_full",   32'(illegal_count), 32'(base + 1));
        hold = 1'b0;
        wait_rsps("t3_rsp", 7, 150);
        repeat (3) @(negedge clk);
        check("t3_level_drained",  32'(level),       0);
        check("t3_rsp_exact",      32'(rsp_count),   7);
        check("t3_ready_pulses",   32'(ready_count), 7);

        // Illegal encodings are dropped and flagged.
        base = illegal_count;
        send(2'b11, 25'h0000010, 16'h0000);
        send(2'b00, 25'h0000011, 16'h0000);
        repeat (2) @(negedge clk);
        check("t4_illegal_pulses", 32'(illegal_count), 32'(base + 2));
        check("t4_level",          32'(level),         0);
        check("t4_no_issue",       32'(ready_count),   7);
        check("t4_req_ready",      32'(req_ready),     1);

        // Timeout: first command never answered, second queued behind it issues normally.
        drop_next = 1'b1;
        lat       = 3;
        send(WR, 25'h0000555, 16'h5555);
        expect_rsp(1'b1, 16'hBEEF, 25'h0000123);
        send(RD, 25'h0000123, 16'h0000);
        n = 0;
        while (!ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t5_issue_seen", 32'(ready), 1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!err_timeout && k < 40);
        // 16 WAIT cycles follow the ISSUE cycle; the pulse shows on the 17th falling edge.
        check("t5_timeout_delay", 32'(k),         17);
        check("t5_cmd_cleared",   32'(cmd),       0);
        check("t5_no_rsp",        32'(rsp_valid), 0);
        check("t5_rsp_count",     32'(rsp_count), 7);
        check("t5_level",         32'(level),     1);
        @(negedge clk);
        check("t5_timeout_pulse", 32'(err_timeout), 0);
        check("t5_next_issue",    32'(ready),       1);
        check("t5_next_cmd",      32'(cmd),         32'(RD));
        check("t5_next_addr",     32'(addr),        32'h0000123);
        wait_rsps("t5_rsp", 8, 40);
        repeat (2) @(negedge clk);
        check("t5_timeout_count", 32'(timeout_count), 1);

        // Asynchronous reset while WAITing with two entries queued.
        hold = 1'b1;
        lat  = 2;
        send(WR, 25'h0000600, 16'h6666);
        send(RD, 25'h0000601, 16'h0000);
        send(WR, 25'h0000602, 16'h6262);
        check("t6_level_pre", 32'(level), 2);
        check("t6_cmd_pre",   32'(cmd),   32'(WR));
        base = ready_count;
        #5;
        rst = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        hold = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("t6_no_rsp",      32'(rsp_count),   8);
        check("t6_no_issue",    32'(ready_count), 32'(base));
        check("t6_level_post",  32'(level),       0);
        check("t6_sb_empty",    32'(sb.size()),   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
